// File: rtl/ysyx_22041211_imm_gen_pkg.sv
// Shared constants for the RV32I immediate generator: opcode values that
// select an immediate format and the format tag codes driven on imm_type.
package ysyx_22041211_imm_gen_pkg;

  // Opcodes (inst[6:0]) that carry an immediate, plus R-type for reference
  localparam logic [6:0] TYPE_R       = 7'b0110011;
  localparam logic [6:0] TYPE_I_BASE  = 7'b0010011;
  localparam logic [6:0] TYPE_I_LOAD  = 7'b0000011;
  localparam logic [6:0] TYPE_I_JALR  = 7'b1100111;
  localparam logic [6:0] TYPE_I_CSR   = 7'b1110011;
  localparam logic [6:0] TYPE_S       = 7'b0100011;
  localparam logic [6:0] TYPE_B       = 7'b1100011;
  localparam logic [6:0] TYPE_U_LUI   = 7'b0110111;
  localparam logic [6:0] TYPE_U_AUIPC = 7'b0010111;
  localparam logic [6:0] TYPE_J_JAL   = 7'b1101111;

  // Format tags reported alongside the immediate
  localparam logic [2:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [2:0] IMM_TYPE_I    = 3'd1;
  localparam logic [2:0] IMM_TYPE_S    = 3'd2;
  localparam logic [2:0] IMM_TYPE_B    = 3'd3;
  localparam logic [2:0] IMM_TYPE_U    = 3'd4;
  localparam logic [2:0] IMM_TYPE_J    = 3'd5;

  // Even parity over an immediate; handy for debug consumers of imm_q
  function automatic logic imm_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/ysyx_22041211_imm_gen.sv
// Immediate generator for the RV32I single-cycle core.
// imm/imm_type are decoded combinationally from the opcode so the decoder can
// use them in the same cycle; imm_q/imm_type_q are a one-cycle registered copy
// intended for trace and debug. funct3/funct7 never influence the result.
module ysyx_22041211_imm_gen
  import ysyx_22041211_imm_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic [2:0]  imm_type,
  output logic [31:0] imm_q,
  output logic [2:0]  imm_type_q
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm;
  logic [2:0]  w_imm_type;
  logic [31:0] r_imm;
  logic [2:0]  r_imm_type;

  assign w_opcode = inst[6:0];

  // Select and assemble the immediate for the format implied by the opcode
  always_comb begin
    w_imm      = 32'h0000_0000;
    w_imm_type = IMM_TYPE_NONE;
    case (w_opcode)
      // Shift-immediates keep the full sign-extended field; the ALU only
      // looks at imm[4:0], so no special casing of funct7 is needed here.
      TYPE_I_BASE, TYPE_I_LOAD, TYPE_I_JALR, TYPE_I_CSR: begin
        w_imm      = {{20{inst[31]}}, inst[31:20]};
        w_imm_type = IMM_TYPE_I;
      end
      TYPE_S: begin
        w_imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        w_imm_type = IMM_TYPE_S;
      end
      TYPE_B: begin
        w_imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                      inst[11:8], 1'b0};
        w_imm_type = IMM_TYPE_B;
      end
      TYPE_U_LUI, TYPE_U_AUIPC: begin
        w_imm      = {inst[31:12], 12'h000};
        w_imm_type = IMM_TYPE_U;
      end
      TYPE_J_JAL: begin
        w_imm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                      inst[30:21], 1'b0};
        w_imm_type = IMM_TYPE_J;
      end
      // R-type and every unrecognised opcode carry no immediate
      default: begin
        w_imm      = 32'h0000_0000;
        w_imm_type = IMM_TYPE_NONE;
      end
    endcase
  end

  // Capture the decoded immediate every cycle; reset clears it immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm      <= 32'h0000_0000;
      r_imm_type <= IMM_TYPE_NONE;
    end else begin
      r_imm      <= w_imm;
      r_imm_type <= w_imm_type;
    end
  end

  assign imm        = w_imm;
  assign imm_type   = w_imm_type;
  assign imm_q      = r_imm;
  assign imm_type_q = r_imm_type;

endmodule

// File: tb/tb_ysyx_22041211_imm_gen.sv
// Table-driven bench for the immediate generator: each vector is checked on
// the combinational outputs and again on the registered copy one edge later,
// followed by hand-written reset sequences.
module tb_ysyx_22041211_imm_gen;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] exp_imm;
    logic [2:0]  exp_type;
    string       name;
  } vec_t;

  localparam int NVEC = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] imm;
  logic [2:0]  imm_type;
  logic [31:0] imm_q;
  logic [2:0]  imm_type_q;

  int checks;
  int failures;
  vec_t vecs [NVEC];

  ysyx_22041211_imm_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .imm        (imm),
    .imm_type   (imm_type),
    .imm_q      (imm_q),
    .imm_type_q (imm_type_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, "addi_m1"};
    vecs[1]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 3'd2, "sw_m4"};
    vecs[2]  = '{32'h0020_8863, 32'h0000_0010, 3'd3, "beq_p16"};
    vecs[3]  = '{32'h1234_52B7, 32'h1234_5000, 3'd4, "lui"};
    vecs[4]  = '{32'hFFDF_F0EF, 32'hFFFF_FFFC, 3'd5, "jal_m4"};
    vecs[5]  = '{32'h0020_81B3, 32'h0000_0000, 3'd0, "add_none"};
    vecs[6]  = '{32'h4050_5293, 32'h0000_0405, 3'd1, "srai"};
    vecs[7]  = '{32'h0081_2083, 32'h0000_0008, 3'd1, "lw_p8"};
    vecs[8]  = '{32'hFF81_00E7, 32'hFFFF_FFF8, 3'd1, "jalr_m8"};
    vecs[9]  = '{32'h3000_9073, 32'h0000_0300, 3'd1, "csrrw"};
    vecs[10] = '{32'hFFFF_F297, 32'hFFFF_F000, 3'd4, "auipc"};
    vecs[11] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'd0, "unknown_op"};
    vecs[12] = '{32'hFFFF_FFE3, 32'hFFFF_FFFE, 3'd3, "b_all_ones"};
    vecs[13] = '{32'h7E20_AFA3, 32'h0000_07FF, 3'd2, "sw_max_pos"};
    vecs[14] = '{32'h0010_006F, 32'h0000_0800, 3'd5, "jal_bit11"};
    vecs[15] = '{32'h0000_00E3, 32'h0000_0800, 3'd3, "b_bit11"};

    // Reset asserted: registered outputs cleared, comb path still live
    rst_n = 1'b0;
    inst  = 32'hFFF0_0093;
    #2;
    chk("reset_imm_q", imm_q, 32'h0);
    chk("reset_type_q", {29'd0, imm_type_q}, 32'd0);
    chk("reset_comb_imm", imm, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("reset_hold_imm_q", imm_q, 32'h0);
    rst_n = 1'b1;

    // Table: combinational result, then registered copy one edge later
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      inst = vecs[i].inst;
      #1;
      chk({vecs[i].name, "_imm"}, imm, vecs[i].exp_imm);
      chk({vecs[i].name, "_type"}, {29'd0, imm_type}, {29'd0, vecs[i].exp_type});
      @(posedge clk); #1;
      chk({vecs[i].name, "_imm_q"}, imm_q, vecs[i].exp_imm);
      chk({vecs[i].name, "_type_q"}, {29'd0, imm_type_q}, {29'd0, vecs[i].exp_type});
    end

    // Mid-operation async reset between edges
    @(negedge clk);
    inst = 32'h4050_5293;
    @(posedge clk); #1;
    chk("srai_pre_rst_imm_q", imm_q, 32'h0000_0405);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_imm_q", imm_q, 32'h0);
    chk("async_rst_type_q", {29'd0, imm_type_q}, 32'd0);
    chk("async_rst_comb_imm", imm, 32'h0000_0405);
    chk("async_rst_comb_type", {29'd0, imm_type}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_capture", imm_q, 32'h0);
    @(posedge clk); #1;
    chk("first_capture_imm_q", imm_q, 32'h0000_0405);
    chk("first_capture_type_q", {29'd0, imm_type_q}, 32'd1);

    // Back-to-back changes: imm_q tracks the previous cycle's inst
    @(negedge clk);
    inst = 32'h1234_52B7;
    @(posedge clk); #1;
    inst = 32'h0020_81B3;
    #1;
    chk("b2b_imm_q_lui", imm_q, 32'h1234_5000);
    chk("b2b_comb_none", imm, 32'h0);
    @(posedge clk); #1;
    chk("b2b_imm_q_none", imm_q, 32'h0);
    chk("b2b_type_q_none", {29'd0, imm_type_q}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
